// File: rtl/vedm_collector_pkg.sv
// Shared defaults, output-register state encoding and width helper for the
// multi-channel data collector.
package vedm_collector_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_CH_DEF   = 4;
    localparam int AVG_LOG2_DEF = 2;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Index width that never collapses to zero bits, even for tiny counts.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dc_channel_acc.sv
// Per-channel block accumulator: sums 2**AVG_LOG2 samples and flags the
// completing sample together with the floored average.
module dc_channel_acc
    import vedm_collector_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              take,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] avg
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    // acc holds at most (2**AVG_LOG2 - 1) full-scale samples, so sum fits in ACC_W.
    assign sum  = acc + ACC_W'(data);
    assign done = take && (cnt == CNT_LAST);
    assign avg  = sum[AVG_LOG2 +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            if (done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_collector_mc.sv
// Multi-channel block-averaging collector with a one-entry valid/ready output
// register, sticky per-channel threshold alarms and a sticky overrun flag.
module data_collector_mc
    import vedm_collector_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int CH_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] thresh,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [DATA_W-1:0] m_data,
    output logic [NUM_CH-1:0] alarm,
    input  logic [NUM_CH-1:0] alarm_clr,
    output logic              overrun,
    input  logic              overrun_clr
);

    logic [NUM_CH-1:0] take;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] alarm_set;
    logic [DATA_W-1:0] avg_ch [NUM_CH];

    logic              cmp;
    logic [CH_W-1:0]   cmp_ch;
    logic [DATA_W-1:0] cmp_avg;

    out_state_t out_state;
    out_state_t out_next;
    logic       load;
    logic       drop;

    // Channel indices at or above NUM_CH match no lane and are ignored.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign take[g] = s_valid && (s_ch == CH_W'(g));

        dc_channel_acc #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .take  (take[g]),
            .data  (s_data),
            .done  (done[g]),
            .avg   (avg_ch[g])
        );

        assign alarm_set[g] = done[g] && (avg_ch[g] > thresh);
    end

    // At most one sample per edge, so at most one lane can complete.
    always_comb begin
        cmp     = 1'b0;
        cmp_ch  = '0;
        cmp_avg = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (done[i]) begin
                cmp     = 1'b1;
                cmp_ch  = CH_W'(i);
                cmp_avg = avg_ch[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_EMPTY;
        end else begin
            out_state <= out_next;
        end
    end

    always_comb begin
        out_next = out_state;
        load     = 1'b0;
        drop     = 1'b0;
        case (out_state)
            OUT_EMPTY: begin
                if (cmp) begin
                    out_next = OUT_FULL;
                    load     = 1'b1;
                end
            end
            OUT_FULL: begin
                if (m_ready) begin
                    if (cmp) begin
                        load = 1'b1;
                    end else begin
                        out_next = OUT_EMPTY;
                    end
                end else if (cmp) begin
                    drop = 1'b1;
                end
            end
            default: out_next = OUT_EMPTY;
        endcase
    end

    assign m_valid = (out_state == OUT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ch   <= '0;
            m_data <= '0;
        end else if (load) begin
            m_ch   <= cmp_ch;
            m_data <= cmp_avg;
        end
    end

    // Sets take priority over same-edge clear strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm   <= '0;
            overrun <= 1'b0;
        end else begin
            alarm   <= (alarm & ~alarm_clr) | alarm_set;
            overrun <= (overrun & ~overrun_clr) | drop;
        end
    end

endmodule
